// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the byte-lane data memory.
// Sizes, request bundle, store byte masks and load extension.
package dmem_pkg;

   localparam int REQ_AW = 64;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_X = 2'd3
   } access_size_e;

   typedef struct packed {
      logic              we;
      access_size_e      size;
      logic              is_signed;
      logic [REQ_AW-1:0] addr;
      logic [31:0]       wdata;
   } dmem_req_t;

   function automatic logic [3:0] byte_mask(
      input access_size_e size,
      input logic [1:0]   lane
   );
      logic [3:0] m;
      m = 4'b0000;
      unique case (size)
         SIZE_B:  m = 4'b0001 << lane;
         SIZE_H:  m = 4'b0011 << lane;
         SIZE_W:  m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] lane_data(
      input access_size_e size,
      input logic [31:0]  wdata
   );
      logic [31:0] d;
      d = wdata;
      unique case (size)
         SIZE_B:  d = {4{wdata[7:0]}};
         SIZE_H:  d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] load_extend(
      input logic [31:0]  word,
      input access_size_e size,
      input logic [1:0]   lane,
      input logic         is_signed
   );
      logic [31:0] s;
      logic [31:0] r;
      s = word >> {lane, 3'b000};
      r = 32'h0;
      unique case (size)
         SIZE_B:  r = {{24{is_signed & s[7]}}, s[7:0]};
         SIZE_H:  r = {{16{is_signed & s[15]}}, s[15:0]};
         SIZE_W:  r = word;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-byte write enables and registered read.
// Kept free of control logic so it maps onto a RAM macro.
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic [3:0]       we,
   input  logic [IDX_W-1:0] waddr,
   input  logic [31:0]      wdata,
   input  logic             re,
   input  logic [IDX_W-1:0] raddr,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with valid/ready request and response,
// error reporting and an optional post-reset clear sweep.
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int DEPTH        = 64,
   parameter int ADDR_W       = 32,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]       state_q;
   logic [IDX_W-1:0] ptr_q;
   logic             clearing;

   dmem_req_t   req;
   logic [REQ_AW-1:0] word_idx;
   logic        in_range;
   logic        misalign;
   logic        req_err;
   logic        fire;

   logic [3:0]       arr_we;
   logic [IDX_W-1:0] arr_waddr;
   logic [31:0]      arr_wdata;
   logic             arr_re;
   logic [31:0]      arr_rdata;

   logic         rsp_valid_q;
   logic         rsp_err_q;
   logic         ld_q;
   access_size_e size_q;
   logic [1:0]   lane_q;
   logic         sgn_q;

   assign req = '{
      we:        req_we,
      size:      access_size_e'(req_size),
      is_signed: req_signed,
      addr:      REQ_AW'(req_addr),
      wdata:     req_wdata
   };

   assign clearing = (state_q == ST_CLEAR);
   assign busy     = clearing;
   assign req_ready = !clearing && (!rsp_valid_q || rsp_ready);
   assign fire     = req_valid && req_ready;

   assign word_idx = req.addr >> 2;
   assign in_range = word_idx < REQ_AW'(DEPTH);

   always_comb begin
      misalign = 1'b0;
      unique case (req.size)
         SIZE_B:  misalign = 1'b0;
         SIZE_H:  misalign = req.addr[0];
         SIZE_W:  misalign = |req.addr[1:0];
         default: misalign = 1'b1;
      endcase
   end

   assign req_err = misalign || !in_range;

   // The sweep owns the write port; requests cannot fire while it runs.
   always_comb begin
      arr_we    = 4'b0000;
      arr_waddr = req.addr[IDX_W+1:2];
      arr_wdata = lane_data(req.size, req.wdata);
      arr_re    = 1'b0;
      if (!rst) begin
         if (clearing) begin
            arr_we    = 4'b1111;
            arr_waddr = ptr_q;
            arr_wdata = 32'h0;
         end else if (fire && !req_err) begin
            if (req.we) begin
               arr_we = byte_mask(req.size, req.addr[1:0]);
            end else begin
               arr_re = 1'b1;
            end
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .waddr (arr_waddr),
      .wdata (arr_wdata),
      .re    (arr_re),
      .raddr (req.addr[IDX_W+1:2]),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         ld_q        <= 1'b0;
         size_q      <= SIZE_B;
         lane_q      <= 2'b00;
         sgn_q       <= 1'b0;
      end else begin
         if (clearing) begin
            ptr_q <= ptr_q + 1'b1;
            if (ptr_q == LAST) begin
               state_q <= ST_RUN;
            end
         end
         if (fire) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= req_err;
            ld_q        <= !req.we && !req_err;
            size_q      <= req.size;
            lane_q      <= req.addr[1:0];
            sgn_q       <= req.is_signed;
         end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   // Array read data only moves on a load fire, so a stalled
   // response stays stable without an extra holding register.
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_valid_q && rsp_err_q;
   assign rsp_rdata = (rsp_valid_q && ld_q)
                    ? load_extend(arr_rdata, size_q, lane_q, sgn_q)
                    : 32'h0;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane: directed cases plus random
// traffic checked against a byte-level memory model.
module tb_dmem_bytelane;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 32;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;

   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   rnd_rdy = 0;
   exp_t exp_q[$];
   logic [31:0] mm [DEPTH];

   dmem_bytelane #(
      .DEPTH        (DEPTH),
      .ADDR_W       (ADDR_W),
      .CLEAR_ON_RST (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endfunction

   // Reference: byte-by-byte store, shift/mask/extend load.
   function automatic void model(input logic we, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] addr,
                                 input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er);
      longint unsigned idx;
      int lane, nb;
      logic [31:0] v, m;
      idx  = addr / 4;
      lane = addr % 4;
      nb   = 1 << sz;
      rd   = 32'h0;
      er   = (sz == 3) || (sz == 1 && lane % 2 != 0) ||
             (sz == 2 && lane != 0) || idx >= DEPTH;
      if (er) return;
      if (we) begin
         for (int i = 0; i < nb; i++)
            mm[idx][8*(lane+i) +: 8] = wd[8*i +: 8];
      end else begin
         v = mm[idx] >> (8 * lane);
         if (nb < 4) begin
            m = (32'h1 << (8 * nb)) - 1;
            v = v & m;
            if (sg && v[8*nb-1]) v = v | ~m;
         end
         rd = v;
      end
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr,
                        input logic [31:0] wd, input bit use_exp,
                        input logic [31:0] xr, input logic xe,
                        output int waits);
      logic [31:0] mr;
      logic        me;
      bit          fired;
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      waits = 0;
      fired = 0;
      while (!fired && waits <= 50) begin
         @(negedge clk);
         if (req_ready) fired = 1;
         else begin
            waits++;
            sync();
            if (rnd_rdy) rsp_ready = 1'b1;
         end
      end
      if (!fired) begin
         n_cmp++;
         n_fail++;
         $display("FAIL issue_timeout: got no fire want fire addr %h", addr);
         req_valid = 1'b0;
         return;
      end
      model(we, sz, sg, addr, wd, mr, me);
      if (use_exp) exp_q.push_back('{rd: xr, err: xe});
      else exp_q.push_back('{rd: mr, err: me});
      sync();
      req_valid = 1'b0;
   endtask

   task automatic d(input logic we, input logic [1:0] sz, input logic sg,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] xr, input logic xe);
      int w;
      issue(we, sz, sg, addr, wd, 1, xr, xe, w);
   endtask

   // Monitor: pop on each response fire, and check stability on stalls.
   initial begin
      exp_t e;
      bit   stalled = 0;
      logic [31:0] h_rd;
      logic        h_err;
      forever begin
         @(negedge clk);
         if (stalled && rsp_valid && !rst) begin
            chk("hold_rdata", rsp_rdata, h_rd);
            chk("hold_err", 32'(rsp_err), 32'(h_err));
         end
         stalled = 0;
         if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL rsp_unexpected: got rdata %h want no response",
                        rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, e.rd);
               chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
         end else if (!rst && rsp_valid) begin
            stalled = 1;
            h_rd    = rsp_rdata;
            h_err   = rsp_err;
         end
      end
   end

   task automatic count_sweep(input string name);
      int cnt = 0;
      int bad = 0;
      while (busy && cnt < 200) begin
         cnt++;
         if (req_ready) bad++;
         @(negedge clk);
      end
      chk(name, cnt, DEPTH);
      chk("ready_in_sweep", bad, 0);
   endtask

   initial begin
      int w;
      int r;
      logic [31:0] a;
      logic [1:0]  sz;
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'd0;
      req_signed = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;

      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      count_sweep("sweep_len");
      sync();

      d(0, 2, 0, 32'h0FC, 0, 32'h0, 0);
      d(1, 2, 0, 32'h010, 32'hDEADBEEF, 32'h0, 0);
      d(1, 0, 0, 32'h013, 32'h000000A5, 32'h0, 0);
      d(0, 2, 0, 32'h010, 0, 32'hA5ADBEEF, 0);
      d(0, 0, 1, 32'h013, 0, 32'hFFFFFFA5, 0);
      d(0, 0, 0, 32'h013, 0, 32'h000000A5, 0);
      d(1, 1, 0, 32'h022, 32'h00008001, 32'h0, 0);
      d(0, 1, 1, 32'h022, 0, 32'hFFFF8001, 0);
      d(0, 1, 0, 32'h020, 0, 32'h00000000, 0);
      d(1, 2, 0, 32'h004, 32'h12345678, 32'h0, 0);
      d(1, 2, 0, 32'h006, 32'hFFFFFFFF, 32'h0, 1);
      d(1, 1, 0, 32'h005, 32'hFFFFFFFF, 32'h0, 1);
      d(1, 3, 0, 32'h004, 32'hFFFFFFFF, 32'h0, 1);
      d(0, 2, 0, 32'h006, 0, 32'h0, 1);
      d(0, 1, 0, 32'h005, 0, 32'h0, 1);
      d(0, 3, 0, 32'h000, 0, 32'h0, 1);
      d(0, 2, 0, 32'h100, 0, 32'h0, 1);
      d(0, 2, 0, 32'h004, 0, 32'h12345678, 0);

      // Stall the consumer for five cycles behind a load.
      sync();
      rsp_ready = 1'b0;
      d(0, 2, 0, 32'h010, 0, 32'hA5ADBEEF, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rdata", rsp_rdata, 32'hA5ADBEEF);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
      end
      sync();
      rsp_ready = 1'b1;
      issue(0, 0, 0, 32'h013, 0, 1, 32'h000000A5, 0, w);
      chk("both_fire_waits", w, 0);
      @(negedge clk);
      chk("next_rsp_valid", 32'(rsp_valid), 32'd1);
      sync();

      // Reset drops a pending response.
      rsp_ready = 1'b0;
      d(0, 2, 0, 32'h004, 0, 32'h12345678, 0);
      @(negedge clk);
      chk("pend_valid", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      sync();
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
      @(negedge clk);
      chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy2", 32'(busy), 32'd1);

      // Restart the sweep from the middle.
      sync();
      repeat (29) sync();
      rst = 1'b1;
      @(negedge clk);
      chk("midsweep_busy", 32'(busy), 32'd1);
      sync();
      rst = 1'b0;
      @(negedge clk);
      count_sweep("resweep_len");
      sync();
      rsp_ready = 1'b1;
      d(0, 2, 0, 32'h010, 0, 32'h0, 0);
      d(0, 2, 0, 32'h004, 0, 32'h0, 0);

      // Random traffic with a randomly stalling consumer.
      rnd_rdy = 1;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) a = $urandom();
         else a = $urandom_range(0, DEPTH * 4 + 15);
         r = $urandom_range(0, 9);
         sz = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         if ($urandom_range(0, 9) < 7) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               a, $urandom(), 0, 32'h0, 1'b0, w);
         if ($urandom_range(0, 3) == 0) sync();
      end
      rnd_rdy = 0;

      rsp_ready = 1'b1;
      r = 0;
      while (exp_q.size() != 0 && r < 20) begin
         sync();
         r++;
      end
      chk("drain_left", exp_q.size(), 0);
      repeat (3) sync();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
